// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_ctrl_pkg
//  Purpose  : Shared types and widths for the SPI register-access controller
//             (state encoding, frame/field widths, half-period counter width).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package spi_ctrl_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LEAD     = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_TRAIL    = 3'd4,
    ST_DONE     = 3'd5,
    ST_GAP      = 3'd6
  } state_t;

endpackage : spi_ctrl_pkg
`default_nettype wire

// File: rtl/spi_half_tick.sv
`default_nettype none
// ============================================================================
//  Module   : spi_half_tick
//  Purpose  : SCLK half-period timer. Counts clk cycles from a restart and
//             asserts o_tick while the count sits at CLK_DIV-1.
//  Ports    : clk       - system clock
//             rst_n     - synchronous active-low reset
//             i_restart - reload the count to zero on the next edge
//             o_tick    - high on the last cycle of a half period
//  Revision : 1.0 - initial release
// ============================================================================
module spi_half_tick
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at c_LAST so states that wait on something else (IDLE) simply
  // keep the tick asserted until the next restart.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (r_cnt != c_LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == c_LAST);

endmodule : spi_half_tick
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
//  Module   : spi_controller
//  Purpose  : Single-frame SPI master (mode 0) for 16-bit register accesses.
//             Frame = {rw, addr[6:0], wdata[7:0]}, MSB first on copi.
//             Optional read capture of the last 8 bits on cipo is enabled by
//             defining SPI_READ_EN; otherwise rdata is tied to zero.
//  Ports    : clk, rst_n (sync, active-low), start, rw, addr, wdata, cipo
//             busy, done, rdata, sclk, ncs, copi
//  Revision : 1.0 - initial release
// ============================================================================
module spi_controller
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              cipo,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              sclk,
  output logic              ncs,
  output logic              copi
);

  state_t             r_state;
  state_t             w_next;
  logic               w_tick;
  logic               w_restart;
  logic               w_accept;
  logic               w_fall;
  logic [FRAME_W-1:0] r_shift;
  logic [3:0]         r_bit;

  // Any state change reloads the half-period timer, so each timed state
  // lasts exactly CLK_DIV cycles from its own entry.
  assign w_restart = (w_next != r_state);
  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_fall    = (r_state == ST_SHIFT_HI) && w_tick;

  spi_half_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_half_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (start)  w_next = ST_LEAD;
      ST_LEAD:     if (w_tick) w_next = ST_SHIFT_HI;
      ST_SHIFT_HI: if (w_tick) w_next = (r_bit == 4'd15) ? ST_TRAIL : ST_SHIFT_LO;
      ST_SHIFT_LO: if (w_tick) w_next = ST_SHIFT_HI;
      ST_TRAIL:    if (w_tick) w_next = ST_DONE;
      ST_DONE:                 w_next = ST_GAP;
      ST_GAP:      if (w_tick) w_next = ST_IDLE;
      default:                 w_next = ST_IDLE;
    endcase
  end

  // The shift register advances only on the falling SCLK transition, which
  // keeps copi stable for the whole high phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_shift <= {rw, addr, wdata};
        r_bit   <= '0;
      end else if (w_fall) begin
        r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
        r_bit   <= r_bit + 1'b1;
      end
    end
  end

`ifdef SPI_READ_EN
  logic              r_rw;
  logic [DATA_W-1:0] r_cap;
  logic [DATA_W-1:0] r_rdata;
  logic              w_rise;

  // Entering SHIFT_HI is the rising SCLK edge; r_bit[3] marks frame bits 7..0.
  assign w_rise = w_tick && ((r_state == ST_LEAD) || (r_state == ST_SHIFT_LO));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rw    <= 1'b0;
      r_cap   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_rw  <= rw;
        r_cap <= '0;
      end else if (w_rise && r_bit[3]) begin
        r_cap <= {r_cap[DATA_W-2:0], cipo};
      end
      // Loaded on the TRAIL->DONE edge so rdata is already valid while done is high.
      if ((r_state == ST_TRAIL) && w_tick && !r_rw) begin
        r_rdata <= r_cap;
      end
    end
  end

  assign rdata = r_rdata;
`else
  logic w_unused_cipo;
  assign w_unused_cipo = cipo;
  assign rdata         = '0;
`endif

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);
  assign sclk = (r_state == ST_SHIFT_HI);
  assign ncs  = !((r_state == ST_LEAD)     || (r_state == ST_SHIFT_HI) ||
                  (r_state == ST_SHIFT_LO) || (r_state == ST_TRAIL));
  assign copi = !ncs && r_shift[FRAME_W-1];

endmodule : spi_controller
`default_nettype wire
